// File: rtl/riscv_alu_pkg.sv
// Shared encodings for the RISC-V ALU control path: ALUctl codes, alu_op classes,
// funct3 values, issue FSM states and the registered per-op control word.
// Pure declarations; no logic and no latency.
package riscv_alu_pkg;

    // ALUctl codes understood by the single-cycle ALU
    localparam logic [3:0] ALUCTL_AND  = 4'd0;
    localparam logic [3:0] ALUCTL_OR   = 4'd1;
    localparam logic [3:0] ALUCTL_ADD  = 4'd2;
    localparam logic [3:0] ALUCTL_IDLE = 4'd3;   // ALU returns 0 for this code
    localparam logic [3:0] ALUCTL_SUB  = 4'd6;
    localparam logic [3:0] ALUCTL_SLT  = 4'd7;
    localparam logic [3:0] ALUCTL_NOR  = 4'd12;

    // Instruction class as produced by the main decoder
    typedef enum logic [1:0] {
        ALU_OP_MEM    = 2'b00,   // load/store address add
        ALU_OP_BRANCH = 2'b01,
        ALU_OP_RTYPE  = 2'b10,
        ALU_OP_ITYPE  = 2'b11
    } alu_op_e;

    // funct3 values this block understands
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Issue controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2,
        ST_HALT  = 2'd3
    } issue_state_e;

    // Control word registered at request acceptance
    typedef struct packed {
        logic [3:0] alu_ctl;
        logic       zero_test;
        logic       is_branch;
        logic       is_bne;
        logic       last;
    } op_ctl_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// Purpose: map (alu_op, funct3, funct7_5) to ALUctl, zero_test and branch/illegal flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, output follows input.
// Ports: alu_op/funct3/funct7_5 in; alu_ctl, zero_test, is_branch, is_bne, illegal out.
// Illegal encodings return the idle ALUctl with zero_test low.
module alu_ctl_decode
    import riscv_alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_ctl,
    output logic       zero_test,
    output logic       is_branch,
    output logic       is_bne,
    output logic       illegal
);

    always_comb begin
        alu_ctl   = ALUCTL_IDLE;
        zero_test = 1'b0;
        is_branch = 1'b0;
        is_bne    = 1'b0;
        illegal   = 1'b0;
        case (alu_op_e'(alu_op))
            ALU_OP_MEM: begin
                alu_ctl = ALUCTL_ADD;
            end
            ALU_OP_BRANCH: begin
                if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                    alu_ctl   = ALUCTL_SUB;
                    zero_test = 1'b1;
                    is_branch = 1'b1;
                    is_bne    = (funct3 == F3_BNE);
                end else begin
                    illegal = 1'b1;
                end
            end
            ALU_OP_RTYPE, ALU_OP_ITYPE: begin
                case (funct3)
                    // funct7_5 selects SUB only for R-type; for I-type it is immediate bits
                    F3_ADD_SUB: alu_ctl = (alu_op_e'(alu_op) == ALU_OP_RTYPE && funct7_5)
                                          ? ALUCTL_SUB : ALUCTL_ADD;
                    F3_AND:     alu_ctl = ALUCTL_AND;
                    F3_OR:      alu_ctl = ALUCTL_OR;
                    F3_SLT:     alu_ctl = ALUCTL_SLT;
                    default:    illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Purpose: issue one decoded op to the ALU, capture its result/zero, return result + branch decision.
// Latency: accept at edge T -> rsp_valid from T+SETTLE_CYCLES+1 (illegal op: from T+1).
// Backpressure: req_ready only in IDLE; response held stable while rsp_ready low; one op in flight.
// Ports: req_* channel from decode (alu_op, funct3, funct7_5, op_a, op_b, last flag);
//        ALUctl/A/B/zero_test/last_instr_flag_out to ALU, ALUout/zero back;
//        rsp_* channel to consumer; halted after the last op retires; taken_cnt of taken branches.
module alu_issue_ctrl
    import riscv_alu_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int SETTLE_CYCLES = 1,    // 1..15
    parameter int CNT_W         = 16
)(
    input  logic              clk,
    input  logic              reset_n,
    // request channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        alu_op,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              last_instr_flag_in,
    // ALU interface
    output logic [3:0]        ALUctl,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              zero_test,
    output logic              last_instr_flag_out,
    input  logic [DATA_W-1:0] ALUout,
    input  logic              zero,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_branch_taken,
    output logic              rsp_illegal,
    // status
    output logic              halted,
    output logic [CNT_W-1:0]  taken_cnt
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    issue_state_e      state_q, state_d;
    op_ctl_t           op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [3:0]        settle_q;

    logic [3:0]        dec_ctl;
    logic              dec_zero_test, dec_is_branch, dec_is_bne, dec_illegal;
    logic              req_fire, rsp_fire, settle_done;

    alu_ctl_decode u_decode (
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .alu_ctl   (dec_ctl),
        .zero_test (dec_zero_test),
        .is_branch (dec_is_branch),
        .is_bne    (dec_is_bne),
        .illegal   (dec_illegal)
    );

    assign req_fire    = req_valid && req_ready;
    assign rsp_fire    = rsp_valid && rsp_ready;
    assign settle_done = (settle_q == SETTLE_LAST);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded outputs. ALU inputs are only non-idle in DRIVE,
    // so an illegal op never reaches the ALU and RESP returns it to the idle code.
    always_comb begin
        state_d             = state_q;
        req_ready           = 1'b0;
        rsp_valid           = 1'b0;
        halted              = 1'b0;
        ALUctl              = ALUCTL_IDLE;
        A                   = '0;
        B                   = '0;
        zero_test           = 1'b0;
        last_instr_flag_out = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = reset_n;
                if (req_valid && reset_n) begin
                    state_d = dec_illegal ? ST_RESP : ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                ALUctl              = op_q.alu_ctl;
                A                   = a_q;
                B                   = b_q;
                zero_test           = op_q.zero_test;
                last_instr_flag_out = op_q.last;
                if (settle_done) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = op_q.last ? ST_HALT : ST_IDLE;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand/control capture, settle counter, response capture and branch counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q              <= '0;
            b_q              <= '0;
            op_q             <= '0;
            settle_q         <= '0;
            rsp_result       <= '0;
            rsp_branch_taken <= 1'b0;
            rsp_illegal      <= 1'b0;
            taken_cnt        <= '0;
        end else begin
            if (req_fire) begin
                a_q              <= op_a;
                b_q              <= op_b;
                op_q.alu_ctl     <= dec_ctl;
                op_q.zero_test   <= dec_zero_test;
                op_q.is_branch   <= dec_is_branch;
                op_q.is_bne      <= dec_is_bne;
                op_q.last        <= last_instr_flag_in;
                settle_q         <= '0;
                // an illegal op goes straight to RESP with a zero result
                rsp_result       <= '0;
                rsp_branch_taken <= 1'b0;
                rsp_illegal      <= dec_illegal;
            end
            if (state_q == ST_DRIVE) begin
                if (settle_done) begin
                    rsp_result       <= ALUout;
                    // BEQ trusts the ALU zero flag; BNE looks at the difference itself
                    rsp_branch_taken <= op_q.is_branch && (op_q.is_bne ? (|ALUout) : zero);
                end else begin
                    settle_q <= settle_q + 4'd1;
                end
            end
            if (rsp_fire && rsp_branch_taken) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    localparam int DW = 32;
    localparam int CW = 16;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // index 0: SETTLE_CYCLES=1, index 1: SETTLE_CYCLES=3
    logic          rst_n      [2];
    logic          req_valid  [2];
    logic          req_ready  [2];
    logic [1:0]    alu_op     [2];
    logic [2:0]    funct3     [2];
    logic          f7         [2];
    logic [DW-1:0] op_a       [2];
    logic [DW-1:0] op_b       [2];
    logic          last_in    [2];
    logic [3:0]    ctl        [2];
    logic [DW-1:0] a_o        [2];
    logic [DW-1:0] b_o        [2];
    logic          zt         [2];
    logic          lf_out     [2];
    logic [DW-1:0] alu_out    [2];
    logic          zero       [2];
    logic          rsp_valid  [2];
    logic          rsp_ready  [2];
    logic [DW-1:0] rsp_result [2];
    logic          rsp_tk     [2];
    logic          rsp_il     [2];
    logic          halted     [2];
    logic [CW-1:0] taken_cnt  [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural single-cycle ALU driven by the DUT
    function automatic logic [DW-1:0] alu_model(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return '0;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_issue_ctrl #(.DATA_W(DW), .SETTLE_CYCLES(g == 0 ? 1 : 3), .CNT_W(CW)) u_dut (
            .clk                 (clk),
            .reset_n             (rst_n[g]),
            .req_valid           (req_valid[g]),
            .req_ready           (req_ready[g]),
            .alu_op              (alu_op[g]),
            .funct3              (funct3[g]),
            .funct7_5            (f7[g]),
            .op_a                (op_a[g]),
            .op_b                (op_b[g]),
            .last_instr_flag_in  (last_in[g]),
            .ALUctl              (ctl[g]),
            .A                   (a_o[g]),
            .B                   (b_o[g]),
            .zero_test           (zt[g]),
            .last_instr_flag_out (lf_out[g]),
            .ALUout              (alu_out[g]),
            .zero                (zero[g]),
            .rsp_valid           (rsp_valid[g]),
            .rsp_ready           (rsp_ready[g]),
            .rsp_result          (rsp_result[g]),
            .rsp_branch_taken    (rsp_tk[g]),
            .rsp_illegal         (rsp_il[g]),
            .halted              (halted[g]),
            .taken_cnt           (taken_cnt[g])
        );
        assign alu_out[g] = alu_model(ctl[g], a_o[g], b_o[g]);
        assign zero[g]    = (alu_out[g] == '0);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Instruction-level reference: what the op means, not how the block encodes it
    function automatic void ref_model(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic legal, output logic [31:0] res, output logic tk);
        legal = 1'b1;
        res   = '0;
        tk    = 1'b0;
        if (op == 2'b00) begin
            res = a + b;
        end else if (op == 2'b01) begin
            res = a - b;
            if (f3 == 3'd0)      tk = (a == b);
            else if (f3 == 3'd1) tk = (a != b);
            else                 legal = 1'b0;
        end else begin
            case (f3)
                3'd0:    res = (op == 2'b10 && f75) ? a - b : a + b;
                3'd7:    res = a & b;
                3'd6:    res = a | b;
                3'd2:    res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: legal = 1'b0;
            endcase
        end
        if (!legal) begin
            res = '0;
            tk  = 1'b0;
        end
    endfunction

    // Called just after a negedge; lat counts negedges since acceptance (1 = cycle T+1)
    task automatic wait_rsp(input int d, inout int lat);
        while (!rsp_valid[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid[d]) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_timeout dut%0d: rsp_valid=0 after %0d cycles, expected 1", d, lat);
        end
    endtask

    // Issue one op from IDLE, snapshot ALU-side outputs in cycle T+1, collect the response
    task automatic run_op(input int d, input logic [1:0] op, input logic [2:0] f3, input logic f75,
                          input logic [31:0] a, input logic [31:0] b, input logic last, input int stall,
                          output int lat, output logic [3:0] c1, output logic z1,
                          output logic [31:0] a1, output logic [31:0] b1, output logic l1,
                          output logic [31:0] res, output logic tk, output logic il);
        alu_op[d]    = op;
        funct3[d]    = f3;
        f7[d]        = f75;
        op_a[d]      = a;
        op_b[d]      = b;
        last_in[d]   = last;
        req_valid[d] = 1'b1;
        rsp_ready[d] = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        c1 = ctl[d];
        z1 = zt[d];
        a1 = a_o[d];
        b1 = b_o[d];
        l1 = lf_out[d];
        lat = 1;
        wait_rsp(d, lat);
        res = rsp_result[d];
        tk  = rsp_tk[d];
        il  = rsp_il[d];
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall rsp_valid", 64'(rsp_valid[d]), 64'd1);
            chk("stall rsp_result", 64'(rsp_result[d]), 64'(res));
            chk("stall req_ready", 64'(req_ready[d]), 64'd0);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        f75;
        logic [31:0] a;
        logic [31:0] b;
        int          stall;
        logic [3:0]  e_ctl;
        logic        e_zt;
        logic [31:0] e_res;
        logic        e_tk;
        logic        e_il;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [3:0]  c1;
        logic        z1, l1, tk, il, legal, etk;
        logic [31:0] a1, b1, res, eres, ra, rb;
        logic [1:0]  rop;
        logic [2:0]  rf3;
        logic        rf7;
        logic [CW-1:0] exp_cnt;
        logic        stale;

        //             op     f3      f7    a             b             st ctl  zt    res           tk    il
        tbl[0]  = '{2'b10, 3'b000, 1'b0, 32'd5,        32'd7,        0, 4'd2, 1'b0, 32'd12,       1'b0, 1'b0};
        tbl[1]  = '{2'b01, 3'b000, 1'b0, 32'h1234,     32'h1234,     0, 4'd6, 1'b1, 32'd0,        1'b1, 1'b0};
        tbl[2]  = '{2'b01, 3'b001, 1'b0, 32'h1234,     32'h1234,     1, 4'd6, 1'b1, 32'd0,        1'b0, 1'b0};
        tbl[3]  = '{2'b10, 3'b001, 1'b0, 32'hAA,       32'h55,       0, 4'd3, 1'b0, 32'd0,        1'b0, 1'b1};
        tbl[4]  = '{2'b10, 3'b000, 1'b1, 32'd3,        32'd5,        2, 4'd6, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[5]  = '{2'b11, 3'b111, 1'b0, 32'hF0F0,     32'hFF00,     0, 4'd0, 1'b0, 32'hF000,     1'b0, 1'b0};
        tbl[6]  = '{2'b10, 3'b110, 1'b0, 32'hF0,       32'h0F,       0, 4'd1, 1'b0, 32'hFF,       1'b0, 1'b0};
        tbl[7]  = '{2'b11, 3'b010, 1'b0, 32'd3,        32'd9,        0, 4'd7, 1'b0, 32'd1,        1'b0, 1'b0};
        tbl[8]  = '{2'b11, 3'b000, 1'b1, 32'd1,        32'd2,        0, 4'd2, 1'b0, 32'd3,        1'b0, 1'b0};
        tbl[9]  = '{2'b00, 3'b101, 1'b0, 32'd100,      32'd8,        0, 4'd2, 1'b0, 32'd108,      1'b0, 1'b0};
        tbl[10] = '{2'b01, 3'b001, 1'b0, 32'd5,        32'd3,        1, 4'd6, 1'b1, 32'd2,        1'b1, 1'b0};
        tbl[11] = '{2'b01, 3'b100, 1'b0, 32'd5,        32'd5,        0, 4'd3, 1'b0, 32'd0,        1'b0, 1'b1};
        tbl[12] = '{2'b11, 3'b001, 1'b0, 32'd7,        32'd7,        0, 4'd3, 1'b0, 32'd0,        1'b0, 1'b1};
        tbl[13] = '{2'b10, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1,        0, 4'd7, 1'b0, 32'd1,        1'b0, 1'b0};
        tbl[14] = '{2'b10, 3'b101, 1'b1, 32'd4,        32'd4,        0, 4'd3, 1'b0, 32'd0,        1'b0, 1'b1};

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; rsp_ready[d] = 1'b0;
            alu_op[d] = '0; funct3[d] = '0; f7[d] = 1'b0;
            op_a[d] = '0; op_b[d] = '0; last_in[d] = 1'b0;
        end

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst ALUctl", 64'(ctl[0]), 64'd3);
        chk("rst A", 64'(a_o[0]), 64'd0);
        chk("rst B", 64'(b_o[0]), 64'd0);
        chk("rst zero_test", 64'(zt[0]), 64'd0);
        chk("rst last_out", 64'(lf_out[0]), 64'd0);
        chk("rst req_ready", 64'(req_ready[0]), 64'd0);
        chk("rst rsp_valid", 64'(rsp_valid[0]), 64'd0);
        chk("rst rsp_result", 64'(rsp_result[0]), 64'd0);
        chk("rst rsp_taken", 64'(rsp_tk[0]), 64'd0);
        chk("rst rsp_illegal", 64'(rsp_il[0]), 64'd0);
        chk("rst halted", 64'(halted[0]), 64'd0);
        chk("rst taken_cnt", 64'(taken_cnt[0]), 64'd0);
        chk("rst ALUctl s3", 64'(ctl[1]), 64'd3);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        #1;
        chk("post-rst req_ready", 64'(req_ready[0]), 64'd1);
        @(negedge clk);

        // ---------------- directed table, SETTLE_CYCLES=1 ----------------
        exp_cnt = '0;
        for (int i = 0; i < 15; i++) begin
            run_op(0, tbl[i].op, tbl[i].f3, tbl[i].f75, tbl[i].a, tbl[i].b, 1'b0, tbl[i].stall,
                   lat, c1, z1, a1, b1, l1, res, tk, il);
            if (tbl[i].e_tk) exp_cnt = exp_cnt + 1'b1;
            chk($sformatf("v%0d ALUctl", i), 64'(c1), 64'(tbl[i].e_ctl));
            chk($sformatf("v%0d zero_test", i), 64'(z1), 64'(tbl[i].e_zt));
            chk($sformatf("v%0d A", i), 64'(a1), tbl[i].e_il ? 64'd0 : 64'(tbl[i].a));
            chk($sformatf("v%0d B", i), 64'(b1), tbl[i].e_il ? 64'd0 : 64'(tbl[i].b));
            chk($sformatf("v%0d latency", i), 64'(lat), tbl[i].e_il ? 64'd1 : 64'd2);
            chk($sformatf("v%0d result", i), 64'(res), 64'(tbl[i].e_res));
            chk($sformatf("v%0d taken", i), 64'(tk), 64'(tbl[i].e_tk));
            chk($sformatf("v%0d illegal", i), 64'(il), 64'(tbl[i].e_il));
            chk($sformatf("v%0d taken_cnt", i), 64'(taken_cnt[0]), 64'(exp_cnt));
            chk($sformatf("v%0d back idle", i), 64'(req_ready[0]), 64'd1);
            chk($sformatf("v%0d idle ALUctl", i), 64'(ctl[0]), 64'd3);
        end

        // ---------------- backpressure: SUB 9-4 held 5 cycles, next req waiting ----------------
        alu_op[0] = 2'b10; funct3[0] = 3'b000; f7[0] = 1'b1;
        op_a[0] = 32'd9; op_b[0] = 32'd4; last_in[0] = 1'b0;
        req_valid[0] = 1'b1; rsp_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        f7[0] = 1'b0; op_a[0] = 32'd1; op_b[0] = 32'd1;   // ADD 1+1 queued behind
        lat = 1;
        wait_rsp(0, lat);
        chk("bp latency", 64'(lat), 64'd2);
        for (int s = 0; s < 5; s++) begin
            chk("bp rsp_valid", 64'(rsp_valid[0]), 64'd1);
            chk("bp rsp_result", 64'(rsp_result[0]), 64'd5);
            chk("bp req_ready", 64'(req_ready[0]), 64'd0);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp after hs rsp_valid", 64'(rsp_valid[0]), 64'd0);
        chk("bp after hs req_ready", 64'(req_ready[0]), 64'd1);
        chk("bp not accepted in hs cycle", 64'(ctl[0]), 64'd3);
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("bp next accepted ALUctl", 64'(ctl[0]), 64'd2);
        chk("bp next accepted A", 64'(a_o[0]), 64'd1);
        lat = 1;
        wait_rsp(0, lat);
        chk("bp next result", 64'(rsp_result[0]), 64'd2);
        @(negedge clk);
        rsp_ready[0] = 1'b0;

        // ---------------- randomized vs reference, SETTLE_CYCLES=3 ----------------
        exp_cnt = '0;
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            rf3 = 3'($urandom_range(0, 7));
            rf7 = 1'($urandom_range(0, 1));
            if (rop == 2'b01 && $urandom_range(0, 1) == 1) rf3 = 3'($urandom_range(0, 1));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            ref_model(rop, rf3, rf7, ra, rb, legal, eres, etk);
            if (etk) exp_cnt = exp_cnt + 1'b1;
            run_op(1, rop, rf3, rf7, ra, rb, 1'b0, int'($urandom_range(0, 2)),
                   lat, c1, z1, a1, b1, l1, res, tk, il);
            chk($sformatf("rnd%0d result", i), 64'(res), 64'(eres));
            chk($sformatf("rnd%0d taken", i), 64'(tk), 64'(etk));
            chk($sformatf("rnd%0d illegal", i), 64'(il), 64'(!legal));
            chk($sformatf("rnd%0d latency", i), 64'(lat), legal ? 64'd4 : 64'd1);
            chk($sformatf("rnd%0d A", i), 64'(a1), legal ? 64'(ra) : 64'd0);
            chk($sformatf("rnd%0d zero_test", i), 64'(z1), (legal && rop == 2'b01) ? 64'd1 : 64'd0);
            chk($sformatf("rnd%0d taken_cnt", i), 64'(taken_cnt[1]), 64'(exp_cnt));
        end

        // ---------------- reset during second DRIVE cycle, SETTLE_CYCLES=3 ----------------
        alu_op[1] = 2'b10; funct3[1] = 3'b000; f7[1] = 1'b0;
        op_a[1] = 32'd1; op_b[1] = 32'd1; last_in[1] = 1'b0;
        req_valid[1] = 1'b1; rsp_ready[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("rdrv first drive ALUctl", 64'(ctl[1]), 64'd2);
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        chk("rdrv ALUctl", 64'(ctl[1]), 64'd3);
        chk("rdrv A", 64'(a_o[1]), 64'd0);
        chk("rdrv rsp_valid", 64'(rsp_valid[1]), 64'd0);
        chk("rdrv req_ready", 64'(req_ready[1]), 64'd0);
        chk("rdrv taken_cnt", 64'(taken_cnt[1]), 64'd0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        #1;
        chk("rdrv release req_ready", 64'(req_ready[1]), 64'd1);
        stale = 1'b0;
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            if (rsp_valid[1] || ctl[1] != 4'd3) stale = 1'b1;
        end
        chk("rdrv no stale response", 64'(stale), 64'd0);
        run_op(1, 2'b10, 3'b000, 1'b0, 32'd2, 32'd3, 1'b0, 0, lat, c1, z1, a1, b1, l1, res, tk, il);
        chk("rdrv next result", 64'(res), 64'd5);
        chk("rdrv next latency", 64'(lat), 64'd4);

        // ---------------- last instruction and halt, SETTLE_CYCLES=1 ----------------
        run_op(0, 2'b10, 3'b010, 1'b0, 32'd3, 32'd9, 1'b1, 0, lat, c1, z1, a1, b1, l1, res, tk, il);
        chk("halt last_out in drive", 64'(l1), 64'd1);
        chk("halt ALUctl SLT", 64'(c1), 64'd7);
        chk("halt result", 64'(res), 64'd1);
        chk("halted", 64'(halted[0]), 64'd1);
        alu_op[0] = 2'b10; funct3[0] = 3'b000; op_a[0] = 32'd1; op_b[0] = 32'd1;
        req_valid[0] = 1'b1;
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            chk($sformatf("halt c%0d req_ready", s), 64'(req_ready[0]), 64'd0);
            chk($sformatf("halt c%0d halted", s), 64'(halted[0]), 64'd1);
            chk($sformatf("halt c%0d ALUctl", s), 64'(ctl[0]), 64'd3);
        end
        chk("halt rsp_valid", 64'(rsp_valid[0]), 64'd0);
        req_valid[0] = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
